// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        HALTED
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one memory port: grant registered at n+1, ack when mem_ready, waits indefinitely.
// Requesters stall (x_req && !x_ack) while not served; MEM_ARB_FAIR_EN swaps fixed priority for alternation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted
);

    arb_state_t        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              halted_q;
    logic              pick_data;

`ifdef MEM_ARB_FAIR_EN
    req_id_t last_grant_q;

    // Fetch only overtakes a pending data request when data won last time.
    assign pick_data = d_req && !(if_req && !halt && (last_grant_q == REQ_D));
`else
    assign pick_data = d_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            last_grant_q <= REQ_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_data) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
`ifdef MEM_ARB_FAIR_EN
                        last_grant_q <= REQ_D;
`endif
                    end else if (halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (if_req) begin
                        state_q    <= BUSY_I;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
`ifdef MEM_ARB_FAIR_EN
                        last_grant_q <= REQ_I;
`endif
                    end
                end
                HALTED: begin
                    // Data accesses still drain after halt so an in-flight store is not lost.
                    if (d_req) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
`ifdef MEM_ARB_FAIR_EN
                        last_grant_q <= REQ_D;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready) begin
                        state_q   <= halted_q ? HALTED : IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack    = (state_q == BUSY_I) && mem_ready;
    assign d_ack     = (state_q == BUSY_D) && mem_ready;
    assign if_rdata  = if_ack ? mem_rdata : '0;
    assign d_rdata   = d_ack ? mem_rdata : '0;
    assign if_stall  = if_req && !if_ack;
    assign d_stall   = d_req && !d_ack;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;

endmodule
